// File: rtl/display_pkg.sv
// Shared types and constants for the signed product seven-segment display.
// The segment codes are active-low and ordered g..a.
package display_pkg;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_MINUS = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } conv_state_t;

    // The number of decimal digits needed for an unsigned value of the given bit width.
    function automatic int bcd_digits(input int bits);
        return (bits * 301) / 1000 + 1;
    endfunction

    function automatic logic [6:0] seg_of(input logic [3:0] nibble);
        logic [6:0] seg;
        case (nibble)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/product_seg_display_bin2bcd_seq.sv
// This module converts a binary value to BCD with the shift-add-3 method, one bit per cycle.
// The converter FSM state is exported on the state port.
module bin2bcd_seq
    import display_pkg::*;
#(
    parameter int BITS       = 16,
    parameter int BCD_DIGITS = 5
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [BITS-1:0]         bin_in,
    output logic                    busy,
    output logic                    done,
    output logic [4*BCD_DIGITS-1:0] bcd_out,
    output conv_state_t             state
);

    localparam int CNT_W = $clog2(BITS);

    logic [CNT_W-1:0]        cnt_q;
    logic [BITS-1:0]         mag_q;
    logic [4*BCD_DIGITS-1:0] bcd_q;
    logic [4*BCD_DIGITS-1:0] bcd_adj;

    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt_q <= '0;
            mag_q <= '0;
            bcd_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        mag_q <= bin_in;
                        bcd_q <= '0;
                        cnt_q <= '0;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    {bcd_q, mag_q} <= {bcd_adj, mag_q} << 1;
                    cnt_q          <= cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(BITS - 1)) begin
                        state <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign busy    = (state == SHIFT);
    assign done    = (state == DONE);
    assign bcd_out = bcd_q;

endmodule

// File: rtl/product_seg_display.sv
// This module shows a signed product as right-aligned decimal on a multiplexed active-low seven-segment display.
// It blanks leading zeros and places a minus sign left of the most significant digit.
module product_seg_display
    import display_pkg::*;
#(
    parameter int BITS           = 16,
    parameter int NUM_SEGMENTS   = 8,
    parameter int REFRESH_CYCLES = 100000
) (
    input  logic                    clk,
    input  logic                    CPU_RESETN,
    input  logic [BITS-1:0]         product_in,
    output logic [NUM_SEGMENTS-1:0] SEG_AN,
    output logic [7:0]              CATHODES
);

    localparam int BCD_DIGITS = bcd_digits(BITS);
    localparam int RC_W       = $clog2(REFRESH_CYCLES);
    localparam int IDX_W      = (NUM_SEGMENTS > 1) ? $clog2(NUM_SEGMENTS) : 1;

    if (BCD_DIGITS + 1 > NUM_SEGMENTS) begin : g_too_few_segments
        $error("product_seg_display: NUM_SEGMENTS too small for sign plus BCD digits");
    end

    conv_state_t             conv_state;
    logic                    conv_busy;
    logic                    conv_done;
    logic [4*BCD_DIGITS-1:0] conv_bcd;
    logic [BITS-1:0]         mag_in;
    logic                    sign_q;

    logic                    disp_blank;
    logic                    disp_sign;
    logic [4*BCD_DIGITS-1:0] disp_bcd;

    logic [RC_W-1:0]         ref_cnt;
    logic [IDX_W-1:0]        idx;
    logic [6:0]              pat;
    int                      msd;

    // The negation of -2^(BITS-1) wraps to 2^(BITS-1), which is the correct unsigned magnitude.
    assign mag_in = product_in[BITS-1] ? BITS'(-product_in) : product_in;

    bin2bcd_seq #(
        .BITS       (BITS),
        .BCD_DIGITS (BCD_DIGITS)
    ) u_bin2bcd (
        .clk     (clk),
        .rst_n   (CPU_RESETN),
        .start   (~conv_busy),
        .bin_in  (mag_in),
        .busy    (conv_busy),
        .done    (conv_done),
        .bcd_out (conv_bcd),
        .state   (conv_state)
    );

    always_ff @(posedge clk or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            sign_q     <= 1'b0;
            disp_blank <= 1'b1;
            disp_sign  <= 1'b0;
            disp_bcd   <= '0;
        end else begin
            if (conv_state == IDLE) begin
                sign_q <= product_in[BITS-1];
            end
            if (conv_done) begin
                disp_blank <= 1'b0;
                disp_sign  <= sign_q;
                disp_bcd   <= conv_bcd;
            end
        end
    end

    always_ff @(posedge clk or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            ref_cnt <= '0;
            idx     <= '0;
        end else if (ref_cnt == RC_W'(REFRESH_CYCLES - 1)) begin
            ref_cnt <= '0;
            idx     <= (idx == IDX_W'(NUM_SEGMENTS - 1)) ? '0 : idx + 1'b1;
        end else begin
            ref_cnt <= ref_cnt + 1'b1;
        end
    end

    // The digit at or right of the most significant nonzero nibble is lit, with digit 0 always lit.
    always_comb begin
        msd = 0;
        pat = SEG_BLANK;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            if (disp_bcd[4*i +: 4] != 4'd0) begin
                msd = i;
            end
        end
        if (!disp_blank) begin
            for (int i = 0; i < BCD_DIGITS; i++) begin
                if (int'(idx) == i && i <= msd) begin
                    pat = seg_of(disp_bcd[4*i +: 4]);
                end
            end
            if (disp_sign && (|disp_bcd) && int'(idx) == msd + 1) begin
                pat = SEG_MINUS;
            end
        end
    end

    always_ff @(posedge clk or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            SEG_AN   <= '1;
            CATHODES <= 8'hFF;
        end else begin
            SEG_AN   <= ~(NUM_SEGMENTS'(1) << idx);
            CATHODES <= {1'b1, pat};
        end
    end

endmodule

// File: doc/product_seg_display.md
# product_seg_display

Downstream display stage for the signed multiplier. It takes the signed `BITS`-wide product and converts its magnitude to BCD with a sequential shift-add-3 (double-dabble) engine. It then shows the signed decimal value on the board's multiplexed, active-low seven-segment display. The result is right-aligned, with leading-zero blanking and a minus sign.

## Interface
Parameters:
- `BITS`, 16, width of the signed product input; 4..16 supported.
- `NUM_SEGMENTS`, 8, number of seven-segment digits/anodes.
- `REFRESH_CYCLES`, 100000, clk cycles each digit stays lit; minimum 2.

Derived localparam:
- `BCD_DIGITS = (BITS*301)/1000 + 1`, which gives 5 for `BITS`=16.
- Elaboration-time assertion: `BCD_DIGITS + 1 <= NUM_SEGMENTS`.

Ports:
- `clk`  in  1  system clock; single clock domain.
- `CPU_RESETN`  in  1  one clock; reset is asynchronous and active-low.
- `product_in`  in  `BITS`  signed product from the multiplier; combinational, sampled at capture.
- `SEG_AN`  out  `NUM_SEGMENTS`  anode enables, active-low, one-hot-low when lit.
- `CATHODES`  out  8  active-low segments: [7]=dp, [6:0]=g..a.

## Operation
Converter FSM, restarting continuously:
- `IDLE`: capture `product_in`.
  - Latch `sign = product_in[BITS-1]`.
  - Latch `mag = sign ? -product_in : product_in` as a `BITS`-bit unsigned value. -2^(BITS-1) yields magnitude 2^(BITS-1), with no overflow.
  - Clear the BCD shift register and go to `SHIFT`.
- `SHIFT`: run `BITS` iterations, one per cycle.
  - Add 3 to every BCD nibble ≥5.
  - Then shift `{bcd, mag}` left by 1.
  - The bit counter reaches `BITS-1` → `DONE`.
- `DONE`: commit `{sign, bcd}` atomically to the display register → `IDLE`.

Input and update rules:
- Changes on `product_in` during `SHIFT` are ignored and picked up at the next `IDLE`.
- The display register changes only in `DONE`, so the display never shows a partial conversion.

Digit mapping (digit 0 = rightmost = `SEG_AN[0]`):
- Digits 0..`BCD_DIGITS-1` show BCD nibbles.
- Blanking: leading zeros are blank. Digit 0 always shows its value, so a value of 0 displays "0".
- Sign: if `sign`=1 and the magnitude is nonzero, a minus (segment g only) appears in the digit immediately left of the most significant nonzero digit. Zero never shows a sign.
- All remaining digits are blank. dp is always off (`CATHODES[7]`=1).

Refresh:
- A cycle counter counts 0..`REFRESH_CYCLES-1` and then wraps.
- On wrap, the digit index advances; it wraps from `NUM_SEGMENTS-1` to 0.
- `SEG_AN` drives low only the current index. `CATHODES` carries that digit's pattern, blank = 8'hFF.

## Timing
- Conversion period: `BITS`+2 cycles (IDLE 1, SHIFT `BITS`, DONE 1).
- Worst-case latency from a stable `product_in` change to display-register update: 2·(`BITS`+2) cycles, which is 36 for `BITS`=16.
- `SEG_AN` and `CATHODES` are registered. They update one cycle after the digit index or display register changes.
- Reset values (asynchronous assertion, synchronous release via the clk edge):
  - FSM in `IDLE`; counters 0; digit index 0.
  - Display register = blank (all digits blank, no sign).
  - `SEG_AN` = all 1s; `CATHODES` = 8'hFF.
  - The first capture occurs on the first clk edge after `CPU_RESETN` rises.
- Reset mid-`SHIFT`: the conversion is abandoned, no commit, and outputs return to the reset values immediately.
- Simultaneous `DONE` commit and digit-index advance: the new display register value is used from the next output cycle. There is no glitch within a lit digit beyond one cycle.

## Structure
- Package `display_pkg`:
  - Cathode constants `SEG_0`..`SEG_9` (0 = 7'b1000000, active-low g..a), `SEG_MINUS` = 7'b0111111, `SEG_BLANK` = 7'b1111111.
  - Converter state enum `{IDLE, SHIFT, DONE}`.
  - Function `bcd_digits(bits)`.
- Sub-module `bin2bcd_seq`:
  - Parameters `BITS`, `BCD_DIGITS`.
  - Ports: `start`/`busy`/`done` pulse, `bin_in`, `bcd_out`.
  - Reusable in later chapters.
- Top level: sign/magnitude capture, blanking/sign logic, refresh multiplexer.

## Test plan
Use `REFRESH_CYCLES`=4 in simulation. Decode the lit digit each refresh and assemble an 8-character string.
- `product_in`=16'h04D2 → after ≤36 cycles, display "    1234". `SEG_AN` scan order is 8'hFE, FD, FB, … 7F, then wraps to FE.
- `product_in`=16'h0000 → "       0"; no minus; digits 1..7 show `CATHODES`=8'hFF.
- `product_in`=16'h8000 → "  -32768"; `product_in`=16'hFFFF → "      -1" (minus on digit 1).
- Change `product_in` from 16'h0064 to 16'hFF9C mid-`SHIFT` → display "     100", then "    -100" within 36 more cycles; never a mixed value.
- Assert `CPU_RESETN`=0 mid-conversion → same-cycle `SEG_AN`=8'hFF and `CATHODES`=8'hFF. After release, with `product_in`=16'h7FFF → "   32767".
- Hold any value 2·`NUM_SEGMENTS`·`REFRESH_CYCLES` cycles → each anode is low exactly `REFRESH_CYCLES` cycles per scan, and never more than one low at once.
